// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Request/response bundle between two SRAM requesters and sram_arbiter.
//   Signals:
//     pX_valid     requester -> arbiter  request pending
//     pX_ready     arbiter -> requester  request accepted this cycle
//     pX_we        requester -> arbiter  1 = write, 0 = read
//     pX_addr      requester -> arbiter  word address
//     pX_wdata     requester -> arbiter  write data
//     pX_mask      requester -> arbiter  byte enables, [1] upper, [0] lower
//     pX_rsp_valid arbiter -> requester  one-cycle completion pulse
//     rsp_rdata    arbiter -> requesters read data, shared by both ports
//   Modports: master (requester side), slave (arbiter side).
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              p0_valid;
  logic              p0_ready;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [1:0]        p0_mask;
  logic              p0_rsp_valid;

  logic              p1_valid;
  logic              p1_ready;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [1:0]        p1_mask;
  logic              p1_rsp_valid;

  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata, p0_mask,
    output p1_valid, p1_we, p1_addr, p1_wdata, p1_mask,
    input  p0_ready, p0_rsp_valid, p1_ready, p1_rsp_valid, rsp_rdata
  );

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata, p0_mask,
    input  p1_valid, p1_we, p1_addr, p1_wdata, p1_mask,
    output p0_ready, p0_rsp_valid, p1_ready, p1_rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter and timing sequencer sharing one external 256Kx16
//   asynchronous SRAM between two requesters. Each access holds the strobes
//   for ACCESS_CYCLES cycles, then spends one TURN cycle with strobes high
//   (write data still driven for hold time) while the owner's rsp_valid pulses.
//   Ports:
//     CLK, reset_in      clock, asynchronous active-high reset
//     bus (slave)        two request ports plus shared read data
//     sram_adr           SRAM word address (holds last value when idle)
//     sram_dat_read      data from pads
//     sram_dat_write     data to pads (holds last value when idle)
//     sram_dat_oe        pad output enable
//     sram_*_n           active-low chip/write/output/byte selects
//     busy               high whenever the sequencer is not idle
module sram_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              reset_in,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_adr,
  input  logic [DATA_W-1:0] sram_dat_read,
  output logic [DATA_W-1:0] sram_dat_write,
  output logic              sram_dat_oe,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_is_write;
  logic [3:0]        r_count;
  logic              r_rsp0;
  logic              r_rsp1;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat_write;
  logic              r_dat_oe;
  logic              r_cs_n;
  logic              r_we_n;
  logic              r_oe_n;
  logic              r_ub_n;
  logic              r_lb_n;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_req;
  logic              w_sel;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_mask;

  // On a tie the port that did not win last time gets the grant, so the two
  // grants are mutually exclusive by construction.
  always_comb begin
    w_grant0 = bus.p0_valid && (!bus.p1_valid || r_last_grant);
    w_grant1 = bus.p1_valid && (!bus.p0_valid || !r_last_grant);
    w_req    = (r_state == IDLE) && (w_grant0 || w_grant1);
    w_sel    = w_grant1;
    w_we     = w_sel ? bus.p1_we    : bus.p0_we;
    w_addr   = w_sel ? bus.p1_addr  : bus.p0_addr;
    w_wdata  = w_sel ? bus.p1_wdata : bus.p0_wdata;
    w_mask   = w_sel ? bus.p1_mask  : bus.p0_mask;
  end

  assign bus.p0_ready     = (r_state == IDLE) && w_grant0;
  assign bus.p1_ready     = (r_state == IDLE) && w_grant1;
  assign bus.p0_rsp_valid = r_rsp0;
  assign bus.p1_rsp_valid = r_rsp1;
  assign bus.rsp_rdata    = r_rdata;

  assign sram_adr       = r_adr;
  assign sram_dat_write = r_dat_write;
  assign sram_dat_oe    = r_dat_oe;
  assign sram_cs_n      = r_cs_n;
  assign sram_we_n      = r_we_n;
  assign sram_oe_n      = r_oe_n;
  assign sram_ub_n      = r_ub_n;
  assign sram_lb_n      = r_lb_n;
  assign busy           = (r_state != IDLE);

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_is_write   <= 1'b0;
      r_count      <= 4'd0;
      r_rsp0       <= 1'b0;
      r_rsp1       <= 1'b0;
      r_rdata      <= '0;
      r_adr        <= '0;
      r_dat_write  <= '0;
      r_dat_oe     <= 1'b0;
      r_cs_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lb_n       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_adr        <= w_addr;
            r_dat_write  <= w_wdata;
            r_cs_n       <= 1'b0;
            r_ub_n       <= ~w_mask[1];
            r_lb_n       <= ~w_mask[0];
            r_we_n       <= ~w_we;
            r_oe_n       <= w_we;
            r_dat_oe     <= w_we;
            r_is_write   <= w_we;
            r_count      <= CNT_LOAD;
            r_last_grant <= w_sel;
            r_owner      <= w_sel;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_count == 4'd0) begin
            // Sample the pads on the last strobe edge, before OE rises.
            if (!r_is_write) begin
              r_rdata <= sram_dat_read;
            end
            r_cs_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_rsp0  <= ~r_owner;
            r_rsp1  <= r_owner;
            r_state <= TURN;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        TURN: begin
          // Pads stay driven through this cycle for write hold time.
          r_dat_oe <= 1'b0;
          r_rsp0   <= 1'b0;
          r_rsp1   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and timing sequencer for the board's external 256Kx16 asynchronous SRAM (18-bit address, 16-bit data, active-low CS/WE/OE/UB/LB).
- Shares the SRAM between two requesters, for example the CPU bus bridge and a DMA or video fetch port.
- Arbitration is round-robin.
- Generates multi-cycle read and write strobes, captures read data and returns a per-port completion pulse.
- Sits between the SoC and the SB_IO tristate data pins.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, number of cycles strobes are held active; legal range 1..15.

Ports:
- CLK  in  1  clock.
- reset_in  in  1  asynchronous, active-high reset.
- p0_valid, p1_valid  in  1  request pending.
- p0_ready, p1_ready  out  1  request accepted this cycle.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  ADDR_W  word address.
- p0_wdata, p1_wdata  in  DATA_W  write data.
- p0_mask, p1_mask  in  2  byte enables; [1] = upper, [0] = lower.
- p0_rsp_valid, p1_rsp_valid  out  1  one-cycle completion pulse (read or write).
- rsp_rdata  out  DATA_W  read data; valid when either rsp_valid is high.
- sram_adr  out  ADDR_W  SRAM address.
- sram_dat_read  in  DATA_W  data from pads.
- sram_dat_write  out  DATA_W  data to pads.
- sram_dat_oe  out  1  pad output enable.
- sram_cs_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1  active-low SRAM controls.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock is CLK; reset is reset_in, asynchronous, active-high.
- Reset values:
  - state = IDLE, last_grant = 1 (so port 0 wins first tie).
  - All *_n outputs = 1, sram_dat_oe = 0, sram_adr = 0, sram_dat_write = 0.
  - rsp_rdata = 0, both rsp_valid = 0, busy = 0.
- States: IDLE -> ACCESS -> TURN -> IDLE.
- IDLE:
  - Grant is combinational. If only one port is valid, grant it. If both are valid, grant the port != last_grant.
  - pX_ready = (state==IDLE) && grant==X. It is never high for both ports, and never high outside IDLE.
  - On the handshake edge (valid & ready):
    - Register addr, wdata and mask into the SRAM outputs.
    - sram_cs_n=0; ub_n=~mask[1]; lb_n=~mask[0].
    - Write: we_n=0, dat_oe=1. Read: oe_n=0.
    - Load counter = ACCESS_CYCLES-1; last_grant = X; go to ACCESS.
- ACCESS:
  - Strobes are held for exactly ACCESS_CYCLES cycles. Counter decrements each cycle.
  - On the edge with counter==0:
    - Read: capture sram_dat_read into rsp_rdata.
    - Drive cs_n, we_n, oe_n, ub_n, lb_n to 1.
    - Assert pX_rsp_valid for the owning port; go to TURN.
- TURN (exactly 1 cycle):
  - pX_rsp_valid is high and all strobes are high.
  - For writes, sram_dat_oe stays 1 and data stays stable (hold time after WE rises).
  - On exit: sram_dat_oe = 0, rsp_valid = 0, go to IDLE.
- Latency: handshake at edge E0; strobes active during cycles 1..ACCESS_CYCLES; rsp_valid during cycle ACCESS_CYCLES+1.
- Throughput: at most one access per ACCESS_CYCLES+2 cycles.
- rsp_rdata holds its last read value until the next read capture. Writes do not alter it.
- sram_adr and sram_dat_write hold their last values in IDLE. Only the strobes and dat_oe return to inactive.
- A requester must hold valid and its payload until ready. Dropping valid before ready is legal and simply withdraws the request.
- A port lowering valid while the other port is granted has no effect on the access in flight.
- Reset mid-access:
  - All strobes go high and dat_oe goes 0 immediately (asynchronous).
  - rsp_valid is cleared; the in-flight access is discarded with no response.
- Mask 2'b00 is legal: the full cycle runs with ub_n = lb_n = 1 and rsp_valid is still returned.

Test Plan:
- Single read, ACCESS_CYCLES=2: p0 read addr 0x1ABCD, SRAM model returns 0x5A5A.
  - Required: oe_n and cs_n low exactly 2 cycles; p0_rsp_valid 1 cycle later with rsp_rdata=0x5A5A; p1_rsp_valid stays 0.
- Write with byte mask: p1 write addr 0x00010, data 0xBEEF, mask 2'b01.
  - Required: we_n low 2 cycles; lb_n=0, ub_n=1; dat_oe high 3 cycles; p1_rsp_valid pulse; SRAM model low byte = 0xEF, high byte unchanged.
- Contention: both ports hold valid continuously for 6 requests each.
  - Required: grants alternate p0, p1, p0, ...; each port receives 6 rsp_valid pulses; IDLE-to-IDLE period = 4 cycles.
- Back-to-back single port: p0 issues 4 reads with p1 idle.
  - Required: p0_ready every 4th cycle; no idle cycles beyond TURN; busy low only on the handshake cycles.
- Reset mid-write: assert reset_in during the second ACCESS cycle.
  - Required: same cycle we_n=1, cs_n=1, dat_oe=0; no rsp_valid; after release, first request is granted normally.
- Boundary ACCESS_CYCLES=1, read at address 0x3FFFF.
  - Required: strobes low 1 cycle; rsp_valid at cycle 2; correct data.
